param_onehot_scan_decoder: RTL and testbench



---
 rtl/param_onehot_scan_decoder.sv | 185 ++++++++++++++++++
 tb/tb_param_onehot_scan_decoder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/param_onehot_scan_decoder.sv
// Registered N-to-2^N one-hot decoder with direct (handshake) and scan modes.
// Optional build macro SCAN_MASK_EN adds scan_mask to skip channels in scan.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   en          - block enable; 0 returns to IDLE with outputs cleared
//   mode        - 0 = direct decode of sel, 1 = scan across all channels
//   in_valid    - sel valid (direct mode)
//   in_ready    - sel accepted this cycle (en && !mode)
//   sel         - select value to decode
//   y           - registered one-hot output
//   cur_sel     - registered binary index of the hot bit
//   out_valid   - y holds a decoded value
//   wrap        - one-cycle pulse when scan returns to the lowest channel
//   scan_mask   - (SCAN_MASK_EN only) 1 skips that channel in scan
module param_onehot_scan_decoder #(
    parameter int SEL_W = 3,
    parameter int DWELL = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        sel,
`ifdef SCAN_MASK_EN
    input  logic [(2**SEL_W)-1:0]   scan_mask,
`endif
    output logic [(2**SEL_W)-1:0]   y,
    output logic [SEL_W-1:0]        cur_sel,
    output logic                    out_valid,
    output logic                    wrap
);

    localparam int OUT_W   = 2 ** SEL_W;
    localparam int DWELL_W = $clog2(DWELL + 1);

    localparam logic [DWELL_W-1:0] DW_LAST = DWELL_W'(DWELL - 1);
    localparam logic [OUT_W-1:0]   ONE     = OUT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        DIRECT,
        SCAN
    } state_t;

    state_t               state_q, state_d;
    logic [OUT_W-1:0]     y_q, y_d;
    logic [SEL_W-1:0]     cur_q, cur_d;
    logic                 ov_q, ov_d;
    logic                 wrap_q, wrap_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;

    logic [OUT_W-1:0]     mask;
    logic                 all_masked;
    logic [SEL_W-1:0]     first_idx;
    logic [SEL_W-1:0]     next_idx;

`ifdef SCAN_MASK_EN
    assign mask = scan_mask;
`else
    assign mask = '0;
`endif

    // Lowest unmasked channel; only meaningful when not all masked.
    function automatic logic [SEL_W-1:0] find_first(
        input logic [OUT_W-1:0] m
    );
        logic [SEL_W-1:0] r;
        logic             found;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < OUT_W; i++) begin
            if (!found && !m[i]) begin
                r     = SEL_W'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Next unmasked channel above cur, wrapping through 0.
    // The final iteration lands back on cur itself, so a single
    // unmasked channel keeps re-selecting itself.
    function automatic logic [SEL_W-1:0] find_next(
        input logic [SEL_W-1:0] cur,
        input logic [OUT_W-1:0] m
    );
        logic [SEL_W-1:0] r;
        logic [SEL_W-1:0] c;
        logic             found;
        r     = cur;
        found = 1'b0;
        for (int i = 1; i <= OUT_W; i++) begin
            c = cur + SEL_W'(i);
            if (!found && !m[c]) begin
                r     = c;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    assign all_masked = &mask;
    assign first_idx  = find_first(mask);
    assign next_idx   = find_next(cur_q, mask);

    assign in_ready = en & ~mode;

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        cur_d   = cur_q;
        ov_d    = ov_q;
        wrap_d  = 1'b0;
        cnt_d   = cnt_q;
        unique case (1'b1)
            !en: begin
                state_d = IDLE;
                y_d     = '0;
                ov_d    = 1'b0;
                cnt_d   = '0;
            end
            en && !mode: begin
                state_d = DIRECT;
                cnt_d   = '0;
                if (in_valid) begin
                    cur_d = sel;
                    y_d   = ONE << sel;
                    ov_d  = 1'b1;
                end
            end
            en && mode: begin
                state_d = SCAN;
                if (all_masked) begin
                    // Nothing to drive; counter frozen.
                    y_d  = '0;
                    ov_d = 1'b0;
                end else if (state_q != SCAN || !ov_q) begin
                    // Entry, or resume after a fully masked period.
                    cur_d = first_idx;
                    y_d   = ONE << first_idx;
                    ov_d  = 1'b1;
                    cnt_d = '0;
                end else if (cnt_q == DW_LAST) begin
                    cnt_d  = '0;
                    cur_d  = next_idx;
                    y_d    = ONE << next_idx;
                    ov_d   = 1'b1;
                    wrap_d = (next_idx <= cur_q);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            y_q     <= '0;
            cur_q   <= '0;
            ov_q    <= 1'b0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            cur_q   <= cur_d;
            ov_q    <= ov_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
        end
    end

    assign y         = y_q;
    assign cur_sel   = cur_q;
    assign out_valid = ov_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_param_onehot_scan_decoder.sv
// Directed bench for param_onehot_scan_decoder.
// Two instances share stimulus: DWELL=2 (u_dut) and DWELL=1 (u_dut1).
module tb_param_onehot_scan_decoder;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       mode;
    logic       in_valid;
    logic [2:0] sel;
`ifdef SCAN_MASK_EN
    logic [7:0] scan_mask;
`endif

    logic       in_ready, out_valid, wrap;
    logic [7:0] y;
    logic [2:0] cur_sel;
    logic       in_ready1, out_valid1, wrap1;
    logic [7:0] y1;
    logic [2:0] cur_sel1;

    int n_cmp;
    int n_bad;

    param_onehot_scan_decoder #(.SEL_W(3), .DWELL(2)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
`ifdef SCAN_MASK_EN
        .scan_mask (scan_mask),
`endif
        .y         (y),
        .cur_sel   (cur_sel),
        .out_valid (out_valid),
        .wrap      (wrap)
    );

    param_onehot_scan_decoder #(.SEL_W(3), .DWELL(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .sel       (sel),
`ifdef SCAN_MASK_EN
        .scan_mask (scan_mask),
`endif
        .y         (y1),
        .cur_sel   (cur_sel1),
        .out_valid (out_valid1),
        .wrap      (wrap1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        mode     = 1'b0;
        in_valid = 1'b0;
        sel      = 3'd0;
`ifdef SCAN_MASK_EN
        scan_mask = 8'h00;
`endif

        // Reset state
        tick();
        tick();
        chk("rst_y", y, 8'h00);
        chk("rst_cur", cur_sel, 3'd0);
        chk("rst_ov", out_valid, 1'b0);
        chk("rst_wrap", wrap, 1'b0);
        chk("rst_y1", y1, 8'h00);

        // Release with a direct transfer already pending
        @(negedge clk);
        rst_n    = 1'b1;
        en       = 1'b1;
        in_valid = 1'b1;
        sel      = 3'd5;
        #1;
        chk("rdy_idle", in_ready, 1'b1);
        tick();
        chk("first_y", y, 8'h20);
        chk("first_cur", cur_sel, 3'd5);
        chk("first_ov", out_valid, 1'b1);
        chk("first_rdy", in_ready, 1'b1);
        chk("first_y1", y1, 8'h20);

        // Back-to-back direct decodes
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            tick();
            chk("dir_y", y, 32'(1) << s);
            chk("dir_cur", cur_sel, s);
        end
        in_valid = 1'b0;
        sel      = 3'd2;
        repeat (3) begin
            tick();
            chk("dir_hold", y, 8'h80);
        end

        // Scan from DIRECT
        mode = 1'b1;
        #1;
        chk("scan_rdy0", in_ready, 1'b0);
        tick();
        chk("scan_entry_y", y, 8'h01);
        chk("scan_entry_cur", cur_sel, 3'd0);
        chk("scan_entry_wrap", wrap, 1'b0);
        chk("scan_entry_ov", out_valid, 1'b1);
        chk("scan_entry_y1", y1, 8'h01);
        chk("scan_entry_wrap1", wrap1, 1'b0);
        for (int e = 1; e <= 40; e++) begin
            tick();
            chk("scan_y", y, 32'(1) << ((e / 2) % 8));
            chk("scan_cur", cur_sel, (e / 2) % 8);
            chk("scan_wrap", wrap, (e % 16) == 0);
            chk("scan_rdy", in_ready, 1'b0);
            chk("scan_y1", y1, 32'(1) << (e % 8));
            chk("scan_wrap1", wrap1, (e % 8) == 0);
        end
        chk("scan_at10", y, 8'h10);

        // Asynchronous reset mid-scan, checked before the next edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_y", y, 8'h00);
        chk("arst_cur", cur_sel, 3'd0);
        chk("arst_ov", out_valid, 1'b0);
        chk("arst_wrap1", wrap1, 1'b0);
        chk("arst_y1", y1, 8'h00);

        // Scan from IDLE, then hand back to direct
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        mode  = 1'b1;
        tick();
        chk("scan2_entry", y, 8'h01);
        repeat (4) tick();
        chk("scan2_y", y, 8'h04);
        chk("scan2_y1", y1, 8'h10);
        mode = 1'b0;
        #1;
        chk("s2d_rdy", in_ready, 1'b1);
        repeat (2) tick();
        chk("s2d_hold_y", y, 8'h04);
        chk("s2d_hold_cur", cur_sel, 3'd2);
        chk("s2d_hold_ov", out_valid, 1'b1);
        chk("s2d_hold_y1", y1, 8'h10);
        sel      = 3'd1;
        in_valid = 1'b1;
        tick();
        chk("s2d_xfer_y", y, 8'h02);
        chk("s2d_xfer_cur", cur_sel, 3'd1);
        chk("s2d_xfer_y1", y1, 8'h02);
        in_valid = 1'b0;
        en       = 1'b0;
        #1;
        chk("dis_rdy", in_ready, 1'b0);
        tick();
        chk("dis_y", y, 8'h00);
        chk("dis_ov", out_valid, 1'b0);
        chk("dis_wrap", wrap, 1'b0);

`ifdef SCAN_MASK_EN
        // Masked scan: channels 1 and 3 only
        scan_mask = 8'hF5;
        en        = 1'b1;
        mode      = 1'b1;
        tick();
        chk("msk_entry_y1", y1, 8'h02);
        chk("msk_entry_wrap1", wrap1, 1'b0);
        chk("msk_entry_y", y, 8'h02);
        tick();
        chk("msk_y1_a", y1, 8'h08);
        chk("msk_wrap1_a", wrap1, 1'b0);
        tick();
        chk("msk_y1_b", y1, 8'h02);
        chk("msk_wrap1_b", wrap1, 1'b1);
        chk("msk_y_b", y, 8'h08);
        tick();
        chk("msk_y1_c", y1, 8'h08);
        chk("msk_wrap1_c", wrap1, 1'b0);
        tick();
        chk("msk_y1_d", y1, 8'h02);
        chk("msk_wrap1_d", wrap1, 1'b1);
        chk("msk_y_d", y, 8'h02);
        chk("msk_wrap_d", wrap, 1'b1);

        // Everything masked
        scan_mask = 8'hFF;
        tick();
        chk("msk_all_y1", y1, 8'h00);
        chk("msk_all_ov1", out_valid1, 1'b0);
        chk("msk_all_y", y, 8'h00);
        tick();
        chk("msk_all_ov", out_valid, 1'b0);

        // Resume on the only unmasked channel
        scan_mask = 8'hDF;
        tick();
        chk("msk_res_y1", y1, 8'h20);
        chk("msk_res_cur1", cur_sel1, 3'd5);
        chk("msk_res_ov1", out_valid1, 1'b1);
        chk("msk_res_wrap1", wrap1, 1'b0);

        // Direct mode decodes a masked channel
        mode     = 1'b0;
        in_valid = 1'b1;
        sel      = 3'd0;
        tick();
        chk("msk_dir_y1", y1, 8'h01);
        in_valid = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
